// File: rtl/matrix_scan_sched.sv
// matrix_scan_sched: round-robin frame scheduler and blanked row scanner for a 4x4 matrix
module matrix_scan_sched #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int DWELL_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p1_req,
    input  logic [15:0] p1_pattern,
    input  logic        p2_req,
    input  logic [15:0] p2_pattern,
    output logic        p1_gnt,
    output logic        p2_gnt,
    output logic [3:0]  row_n,
    output logic [3:0]  col,
    output logic        frame_start,
    output logic [1:0]  owner
);
    typedef enum logic [1:0] {LOAD, SHOW, BLANK} state_t;
    localparam logic [DWELL_W-1:0] DWELL_LD  = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DWELL_W-1:0] BLANK_LD  = DWELL_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam bit                 HAS_BLANK = BLANK_CYCLES > 0;
    state_t             state, state_d;
    logic [1:0]         row, row_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [15:0]        frame_buf, buf_d;
    logic [3:0]         row_n_d, col_d;
    logic               last_p2;
    logic               load;
    // LOAD is gated by rst_n so nothing pulses while reset is held
    assign load        = state == LOAD && rst_n;
    assign frame_start = load;
    assign p1_gnt      = load && p1_req && (!p2_req || last_p2);
    assign p2_gnt      = load && p2_req && (!p1_req || !last_p2);
    always_comb begin
        state_d = state;
        row_d   = row;
        cnt_d   = cnt;
        if (state == LOAD) begin
            state_d = SHOW;
            row_d   = 2'd0;
            cnt_d   = DWELL_LD;
        end else if (cnt != '0) begin
            cnt_d = cnt - DWELL_W'(1);
        end else if (state == SHOW && HAS_BLANK) begin
            state_d = BLANK;
            cnt_d   = BLANK_LD;
        end else if (row == 2'd3) begin
            state_d = LOAD;
        end else begin
            state_d = SHOW;
            row_d   = row + 2'd1;
            cnt_d   = DWELL_LD;
        end
        buf_d   = p1_gnt ? p1_pattern : p2_gnt ? p2_pattern : frame_buf;
        // outputs are decoded from the next state so they register in step with it
        row_n_d = state_d == SHOW ? ~(4'b0001 << row_d) : 4'hF;
        col_d   = state_d == SHOW ? buf_d[{row_d, 2'b00} +: 4] : 4'h0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            row       <= 2'd0;
            cnt       <= '0;
            frame_buf <= 16'h0;
            owner     <= 2'b00;
            last_p2   <= 1'b1;
            row_n     <= 4'hF;
            col       <= 4'h0;
        end else begin
            state     <= state_d;
            row       <= row_d;
            cnt       <= cnt_d;
            frame_buf <= buf_d;
            owner     <= p1_gnt ? 2'b01 : p2_gnt ? 2'b10 : owner;
            last_p2   <= p2_gnt ? 1'b1 : p1_gnt ? 1'b0 : last_p2;
            row_n     <= row_n_d;
            col       <= col_d;
        end
    end
endmodule

// File: tb/tb_matrix_scan_sched.sv
// tb_matrix_scan_sched: directed checks of frame timing, arbitration, scanning and reset
module tb_matrix_scan_sched;
    logic        clk;
    logic        rst_n, p1_req, p2_req;
    logic [15:0] p1_pattern, p2_pattern;
    logic        p1_gnt, p2_gnt, frame_start;
    logic [3:0]  row_n, col;
    logic [1:0]  owner;
    logic        rst2_n, q1_req;
    logic [15:0] q1_pattern;
    logic        q1_gnt, q2_gnt, frame_start2;
    logic [3:0]  row_n2, col2;
    logic [1:0]  owner2;
    int tests, fails;

    matrix_scan_sched #(.DWELL_CYCLES(4), .BLANK_CYCLES(1), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .p1_req(p1_req), .p1_pattern(p1_pattern),
        .p2_req(p2_req), .p2_pattern(p2_pattern), .p1_gnt(p1_gnt), .p2_gnt(p2_gnt),
        .row_n(row_n), .col(col), .frame_start(frame_start), .owner(owner)
    );

    matrix_scan_sched #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .DWELL_W(16)) dut_nb (
        .clk(clk), .rst_n(rst2_n), .p1_req(q1_req), .p1_pattern(q1_pattern),
        .p2_req(1'b0), .p2_pattern(16'h0), .p1_gnt(q1_gnt), .p2_gnt(q2_gnt),
        .row_n(row_n2), .col(col2), .frame_start(frame_start2), .owner(owner2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called inside a LOAD cycle; returns at the negedge of the following LOAD cycle.
    task automatic frame_check(input logic [15:0] pat, input logic g1, input logic g2,
                               input logic [1:0] own, input int chg_cyc, input logic [15:0] chg_val);
        #1;
        check("load_frame_start", {15'h0, frame_start}, 16'h1);
        check("load_p1_gnt", {15'h0, p1_gnt}, {15'h0, g1});
        check("load_p2_gnt", {15'h0, p2_gnt}, {15'h0, g2});
        check("load_row_n", {12'h0, row_n}, 16'hF);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == chg_cyc) p1_pattern = chg_val;
            if ((c - 1) % 5 < 4) begin
                check("show_row_n", {12'h0, row_n}, {12'h0, ~(4'b0001 << ((c - 1) / 5))});
                check("show_col", {12'h0, col}, {12'h0, pat[((c - 1) / 5) * 4 +: 4]});
            end else begin
                check("blank_row_n", {12'h0, row_n}, 16'hF);
                check("blank_col", {12'h0, col}, 16'h0);
            end
            check("mid_frame_start", {15'h0, frame_start}, 16'h0);
            check("mid_gnt", {14'h0, p1_gnt, p2_gnt}, 16'h0);
            check("owner", {14'h0, owner}, {14'h0, own});
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; p1_req = 1'b0; p2_req = 1'b0;
        p1_pattern = 16'h0; p2_pattern = 16'h0;
        rst2_n = 1'b0; q1_req = 1'b1; q1_pattern = 16'hC3A5;
        repeat (3) begin
            @(negedge clk);
            check("rst_row_n", {12'h0, row_n}, 16'hF);
            check("rst_col", {12'h0, col}, 16'h0);
            check("rst_owner", {14'h0, owner}, 16'h0);
            check("rst_frame_start", {15'h0, frame_start}, 16'h0);
        end
        rst_n = 1'b1;
        frame_check(16'h0000, 1'b0, 1'b0, 2'b00, -1, 16'h0);
        p1_req = 1'b1; p1_pattern = 16'hB0A5;
        frame_check(16'hB0A5, 1'b1, 1'b0, 2'b01, -1, 16'h0);
        p1_pattern = 16'h000F;
        frame_check(16'h000F, 1'b1, 1'b0, 2'b01, 3, 16'hFFFF);
        frame_check(16'hFFFF, 1'b1, 1'b0, 2'b01, -1, 16'h0);
        p1_req = 1'b0;
        frame_check(16'hFFFF, 1'b0, 1'b0, 2'b01, -1, 16'h0);
        p2_req = 1'b1; p2_pattern = 16'h1234;
        frame_check(16'h1234, 1'b0, 1'b1, 2'b10, -1, 16'h0);
        p1_req = 1'b1; p2_req = 1'b0; p1_pattern = 16'hAAAA;
        #1;
        check("pre_rst_p1_gnt", {15'h0, p1_gnt}, 16'h1);
        repeat (12) @(negedge clk);
        check("show2_row_n", {12'h0, row_n}, 16'hB);
        p2_req = 1'b1; p2_pattern = 16'h5555;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_row_n", {12'h0, row_n}, 16'hF);
        check("midrst_col", {12'h0, col}, 16'h0);
        check("midrst_owner", {14'h0, owner}, 16'h0);
        check("midrst_gnt", {14'h0, p1_gnt, p2_gnt}, 16'h0);
        check("midrst_frame_start", {15'h0, frame_start}, 16'h0);
        rst_n = 1'b1;
        frame_check(16'hAAAA, 1'b1, 1'b0, 2'b01, -1, 16'h0);
        frame_check(16'h5555, 1'b0, 1'b1, 2'b10, -1, 16'h0);
        frame_check(16'hAAAA, 1'b1, 1'b0, 2'b01, -1, 16'h0);
        frame_check(16'h5555, 1'b0, 1'b1, 2'b10, -1, 16'h0);
        rst2_n = 1'b1;
        #1;
        check("nb_load_frame_start", {15'h0, frame_start2}, 16'h1);
        check("nb_load_gnt", {15'h0, q1_gnt}, 16'h1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("nb_row_n", {12'h0, row_n2}, {12'h0, ~(4'b0001 << ((c - 1) / 4))});
            check("nb_col", {12'h0, col2}, {12'h0, q1_pattern[((c - 1) / 4) * 4 +: 4]});
            check("nb_frame_start", {15'h0, frame_start2}, 16'h0);
        end
        @(negedge clk);
        check("nb_period_frame_start", {15'h0, frame_start2}, 16'h1);
        check("nb_load_row_n", {12'h0, row_n2}, 16'hF);
        check("nb_owner", {14'h0, owner2}, 16'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matrix_scan_sched.md
Name: matrix_scan_sched

Overview:
Frame scheduler and row scanner for the 4x4 workshop matrix. Two player requesters (p1, p2) each offer a 16-bit matrix pattern. Once per frame the block arbitrates round-robin between them and latches the winner into a frame buffer. It then scans that buffer row by row onto active-low row selects and column data, with a blanking gap between rows to suppress ghosting.

Parameters:
DWELL_CYCLES, 1000, clocks each row is driven; legal range 1..2^DWELL_W-1
BLANK_CYCLES, 2, all-off clocks after each row; 0 legal (no gap)
DWELL_W, 16, counter width for the dwell and blank counters

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
p1_req  in  1  player 1 requests display; held until p1_gnt
p1_pattern  in  16  player 1 matrix pattern, bit index = row*4+col
p2_req  in  1  player 2 requests display; held until p2_gnt
p2_pattern  in  16  player 2 matrix pattern, same mapping
p1_gnt  out  1  one-cycle pulse: p1_pattern captured
p2_gnt  out  1  one-cycle pulse: p2_pattern captured
row_n  out  4  active-low row select; at most one bit low
col  out  4  column data for the selected row
frame_start  out  1  one-cycle pulse in each LOAD cycle
owner  out  2  current frame owner: 00 none, 01 p1, 10 p2

Behaviour:
- One clock domain. Reset is synchronous, active-low: rst_n is sampled on rising clk only.
- Values while rst_n is low: row_n=4'b1111, col=0, p1_gnt=p2_gnt=0, frame_start=0, owner=00, frame buffer=0, last_grant=p2 (so p1 wins the first tie), state=LOAD.
- States: LOAD -> SHOW(r) -> BLANK(r) -> SHOW(r+1) ... -> BLANK(3) -> LOAD.
- LOAD (exactly 1 cycle):
  - frame_start=1; row_n=1111; col=0.
  - Only p1_req: capture p1_pattern, p1_gnt=1, owner<=01, last_grant<=p1.
  - Only p2_req: capture p2_pattern, p2_gnt=1, owner<=10, last_grant<=p2.
  - Both requests: grant the player not equal to last_grant.
  - No request: buffer, owner and last_grant unchanged; no gnt pulse.
  - The pattern is sampled only in the LOAD cycle. A request dropped before LOAD is not seen.
- SHOW(r), DWELL_CYCLES cycles:
  - row_n has only bit r low; col=buffer[4r+3:4r].
  - The outputs are registered and valid from the first SHOW cycle.
- BLANK(r), BLANK_CYCLES cycles:
  - row_n=1111, col=0.
  - With BLANK_CYCLES=0 the state is skipped and SHOW(r) goes directly to SHOW(r+1), or to LOAD after row 3.
- Frame length = 1 + 4*(DWELL_CYCLES+BLANK_CYCLES) clocks. frame_start pulses repeat at exactly this period.
- Row counter: 2-bit, wraps 3 -> 0 only via LOAD.
- Changes to p*_pattern after a grant do not affect the display until the next LOAD.
- owner holds its value across frames that have no request.
- Reset mid-frame: the next rising edge with rst_n=0 forces all reset values. On release, the first cycle is LOAD.
- row_n never has more than one bit low in any cycle, including transition cycles.

Test Plan:
All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=1 (frame = 21 clocks) unless stated.

1. Reset, then idle:
   - Stimulus: hold rst_n=0 for 3 clocks.
   - Required: row_n=1111, col=0, owner=00 during reset.
   - Stimulus: release with no requests.
   - Required: frame_start at cycle 0; row_n=1110, col=0 for cycles 1-4; row_n=1111 at cycle 5; frame_start again at cycle 21; no gnt pulses.
2. Single grant:
   - Stimulus: p1_req=1, p1_pattern=16'hB0A5.
   - Required: p1_gnt pulse in LOAD; owner=01.
   - Required: row0 col=5 (cycles 1-4), row1 col=A (cycles 6-9), row2 col=0 (cycles 11-14), row3 col=B (cycles 16-19); row_n=1111 on cycles 5, 10, 15, 20.
3. Round-robin:
   - Stimulus: p1_req and p2_req both held high from reset.
   - Required: grants p1, p2, p1, p2 on consecutive frames; gnt pulses 21 cycles apart; owner toggles 01/10.
4. Late pattern change:
   - Stimulus: p1 is granted 16'h000F; at cycle 3, p1_pattern changes to 16'hFFFF.
   - Required: rows 1-3 of that frame show col=0; the new pattern appears only after the next grant.
5. Reset mid-frame:
   - Stimulus: assert rst_n=0 during SHOW(2).
   - Required: next edge gives row_n=1111, owner=00. After release, the first cycle is LOAD and p1 wins a tie.
6. No blanking:
   - Stimulus: BLANK_CYCLES=0, DWELL_CYCLES=4.
   - Required: rows are contiguous, frame_start period is 17 clocks, no cycle has row_n=1111 except LOAD.
